char_stream_arbiter: RTL and testbench

CHAR_STREAM_ARBITER -- requirements
Module: char_stream_arbiter

---
 rtl/ascii_pkg.sv | 13 +
 rtl/char_serializer.sv | 55 +++++
 rtl/char_stream_arbiter.sv | 130 +++++++++++++
 tb/tb_char_stream_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
// Shared constants and FSM state type for the character stream arbiter.
package ascii_pkg;

    localparam int unsigned CHAR_W_DEFAULT  = 7;
    localparam int unsigned TIMEOUT_DEFAULT = 15;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StWait
    } state_e;

endpackage

// File: rtl/char_serializer.sv
// MSB-first parallel-to-serial shifter; emits one bit per cycle for CHAR_W cycles after load.
module char_serializer
    import ascii_pkg::*;
#(
    parameter int unsigned CHAR_W = CHAR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CHAR_W-1:0] char,
    output logic              ser_bit,
    output logic              ser_en,
    output logic              last
);
    localparam int unsigned CntW = (CHAR_W > 1) ? $clog2(CHAR_W) : 1;

    logic [CHAR_W-1:0] sreg_q, sreg_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              active_q, active_d;

    assign last    = active_q && (cnt_q == CntW'(CHAR_W - 1));
    assign ser_en  = active_q;
    // Gated so the line idles low outside a transfer and during reset.
    assign ser_bit = active_q & sreg_q[CHAR_W-1];

    always_comb begin
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        if (load) begin
            sreg_d   = char;
            cnt_d    = '0;
            active_d = 1'b1;
        end else if (active_q) begin
            sreg_d = sreg_q << 1;
            cnt_d  = cnt_q + CntW'(1);
            if (last) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/char_stream_arbiter.sv
// Round-robin arbiter feeding two character requesters into one shared serial converter.
// Define ECHO_CHECK_EN to compare the converter's decoded character against the one sent.
module char_stream_arbiter
    import ascii_pkg::*;
#(
    parameter int unsigned CHAR_W  = CHAR_W_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [CHAR_W-1:0] req_char0,
    input  logic [CHAR_W-1:0] req_char1,
    output logic [1:0]        req_ready,
    output logic              ser_bit,
    output logic              ser_en,
    input  logic              conv_done,
    input  logic [CHAR_W-1:0] conv_char,
    output logic              grant_id,
    output logic              busy,
    output logic              err_timeout,
    output logic              err_mismatch
);
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_id_q, grant_id_d;
    logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
    logic              winner;
    logic              grant;
    logic [CHAR_W-1:0] load_char;
    logic              ser_last;

    // Contention goes to whoever did not complete the last transfer.
    assign winner    = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
    assign grant     = rst && (state_q == StIdle) && (|req_valid);
    assign req_ready = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
    assign load_char = winner ? req_char1 : req_char0;
    assign busy      = (state_q != StIdle);
    assign grant_id  = grant_id_q;

    char_serializer #(
        .CHAR_W (CHAR_W)
    ) u_serializer (
        .clk     (clk),
        .rst     (rst),
        .load    (grant),
        .char    (load_char),
        .ser_bit (ser_bit),
        .ser_en  (ser_en),
        .last    (ser_last)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        wait_cnt_d   = wait_cnt_q;
        err_timeout  = 1'b0;
        unique case (state_q)
            StIdle: begin
                wait_cnt_d = '0;
                if (grant) begin
                    state_d    = StShift;
                    grant_id_d = winner;
                end
            end
            StShift: begin
                if (ser_last) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                wait_cnt_d = wait_cnt_q + CntW'(1);
                // A completion on the final allowed cycle still counts as success.
                if (conv_done) begin
                    state_d      = StIdle;
                    last_grant_d = grant_id_q;
                end else if (wait_cnt_q == CntW'(TIMEOUT)) begin
                    err_timeout = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            grant_id_q   <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

`ifdef ECHO_CHECK_EN
    logic [CHAR_W-1:0] sent_q;
    logic              err_mismatch_q;
    logic              accept;

    assign accept       = (state_q == StWait) && conv_done;
    assign err_mismatch = err_mismatch_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sent_q         <= '0;
            err_mismatch_q <= 1'b0;
        end else begin
            if (grant) begin
                sent_q <= load_char;
            end
            if (accept && (conv_char != sent_q)) begin
                err_mismatch_q <= 1'b1;
            end
        end
    end
`else
    logic unused_conv_char;
    assign unused_conv_char = ^conv_char;
    assign err_mismatch     = 1'b0;
`endif

endmodule

// File: tb/tb_char_stream_arbiter.sv
// Self-checking bench: directed transfer table, mid-shift reset and randomized transfers.
`timescale 1ns/1ps
module tb_char_stream_arbiter;
    localparam int unsigned CW = 7;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req_valid;
    logic [CW-1:0] req_char0, req_char1, conv_char;
    logic [1:0]    req_ready;
    logic          ser_bit, ser_en, conv_done, grant_id, busy, err_timeout, err_mismatch;

    char_stream_arbiter #(
        .CHAR_W  (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_char0    (req_char0),
        .req_char1    (req_char1),
        .req_ready    (req_ready),
        .ser_bit      (ser_bit),
        .ser_en       (ser_en),
        .conv_done    (conv_done),
        .conv_char    (conv_char),
        .grant_id     (grant_id),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_mismatch (err_mismatch)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [1:0]    v;
        logic [CW-1:0] c0;
        logic [CW-1:0] c1;
        int            done_at;    // WAIT cycle carrying conv_done; > TO means never
        bit            shift_done; // also pulse conv_done in shift cycle 2
        bit            hold;       // keep req_valid high through the transfer
        bit            bad_echo;   // return a corrupted conv_char
        bit            poke;       // requester 1 raises valid mid-shift, drops before IDLE
        logic          ew;         // expected winner
        bit            etimeout;   // expected timeout
    } vec_t;

    int   total = 0;
    int   bad = 0;
    int   cyc_n = 0;
    int   prev_grant = -1;
    logic rr_last;
    logic mm_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic model_reset();
        rr_last    = 1'b1;
        mm_exp     = 1'b0;
        prev_grant = -1;
    endtask

    // Asserts reset away from the clock edge and checks the held-reset outputs at once.
    task automatic pulse_reset(input string tag);
        rst = 1'b0;
        #1;
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ser_en"}, ser_en, 0);
        check({tag, "_ser_bit"}, ser_bit, 0);
        check({tag, "_ready"}, req_ready, 0);
        check({tag, "_gid"}, grant_id, 0);
        check({tag, "_tmo"}, err_timeout, 0);
        check({tag, "_mm"}, err_mismatch, 0);
        cyc();
        cyc();
        rst = 1'b1;
        model_reset();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid = 2'b00;
            conv_done = 1'b0;
            #2;
            check("idle_busy", busy, 0);
            check("idle_ready", req_ready, 0);
            check("idle_ser_en", ser_en, 0);
            cyc();
        end
    endtask

    // One complete transfer, starting in an IDLE cycle and ending in the next IDLE cycle.
    task automatic run_xfer(input vec_t t);
        logic [CW-1:0] ch;
        bit            done;
        req_valid = t.v;
        req_char0 = t.c0;
        req_char1 = t.c1;
        conv_done = 1'b0;
        #2;
        check("grant_idle", busy, 0);
        check("grant_ready", req_ready, t.ew ? 2'b10 : 2'b01);
        if (prev_grant >= 0) check("grant_gap", (cyc_n - prev_grant) >= int'(CW) + 2, 1);
        prev_grant = cyc_n;
        ch = t.ew ? t.c1 : t.c0;
        cyc();
        if (!t.hold) req_valid = 2'b00;
        for (int k = 0; k < int'(CW); k++) begin
            if (t.poke) req_valid = (k >= 1 && k <= 3) ? 2'b10 : 2'b00;
            conv_done = t.shift_done && (k == 2);
            conv_char = ch ^ 7'h01;
            #2;
            check("shift_en", ser_en, 1);
            check("shift_bit", ser_bit, ch[CW-1-k]);
            check("shift_busy", busy, 1);
            check("shift_gid", grant_id, t.ew);
            check("shift_ready", req_ready, 0);
            check("shift_tmo", err_timeout, 0);
            cyc();
        end
        if (t.poke) req_valid = 2'b00;
        done = 1'b0;
        for (int j = 0; j <= int'(TO); j++) begin
            conv_done = (j == t.done_at);
            conv_char = t.bad_echo ? (ch ^ 7'h01) : ch;
            #2;
            check("wait_en", ser_en, 0);
            check("wait_busy", busy, 1);
            check("wait_ready", req_ready, 0);
            check("wait_gid", grant_id, t.ew);
            check("wait_tmo", err_timeout, (j == int'(TO)) && t.etimeout);
            check("wait_mm", err_mismatch, mm_exp);
            if (conv_done) done = 1'b1;
            if (done || j == int'(TO)) break;
            cyc();
        end
        cyc();
        conv_done = 1'b0;
        if (done) rr_last = t.ew;
`ifdef ECHO_CHECK_EN
        if (done && t.bad_echo) mm_exp = 1'b1;
`endif
        #2;
        check("end_busy", busy, 0);
        check("end_ser_en", ser_en, 0);
        check("end_tmo", err_timeout, 0);
        check("end_mm", err_mismatch, mm_exp);
    endtask

    vec_t vt[12];
    vec_t rt;

    initial begin
        vt[0]  = '{2'b11, 7'h41, 7'h42,  0, 0, 1, 0, 0, 1'b0, 0};
        vt[1]  = '{2'b11, 7'h41, 7'h42,  1, 0, 1, 0, 0, 1'b1, 0};
        vt[2]  = '{2'b11, 7'h41, 7'h42,  0, 0, 1, 0, 0, 1'b0, 0};
        vt[3]  = '{2'b11, 7'h41, 7'h42,  3, 0, 0, 0, 0, 1'b1, 0};
        vt[4]  = '{2'b01, 7'h48, 7'h00,  2, 0, 0, 0, 0, 1'b0, 0};
        vt[5]  = '{2'b10, 7'h00, 7'h5A, 99, 0, 0, 0, 0, 1'b1, 1};
        vt[6]  = '{2'b11, 7'h7F, 7'h00, 15, 0, 0, 0, 0, 1'b1, 0};
        vt[7]  = '{2'b01, 7'h2A, 7'h00,  4, 1, 0, 0, 1, 1'b0, 0};
        vt[8]  = '{2'b11, 7'h11, 7'h22, 15, 0, 0, 0, 0, 1'b1, 0};
        vt[9]  = '{2'b01, 7'h65, 7'h00,  2, 0, 0, 1, 0, 1'b0, 0};
        vt[10] = '{2'b10, 7'h00, 7'h01,  0, 0, 0, 0, 0, 1'b1, 0};
        vt[11] = '{2'b11, 7'h12, 7'h34,  5, 0, 0, 0, 0, 1'b0, 0};

        rst       = 1'b0;
        req_valid = 2'b11;
        req_char0 = 7'h41;
        req_char1 = 7'h42;
        conv_done = 1'b1;
        conv_char = '0;
        model_reset();
        #3;
        check("rst_busy", busy, 0);
        check("rst_ready", req_ready, 0);
        check("rst_ser_en", ser_en, 0);
        check("rst_ser_bit", ser_bit, 0);
        check("rst_gid", grant_id, 0);
        check("rst_tmo", err_timeout, 0);
        check("rst_mm", err_mismatch, 0);
        cyc();
        cyc();
        rst       = 1'b1;
        req_valid = 2'b00;
        conv_done = 1'b0;
        idle_cycles(1);

        foreach (vt[i]) begin
            run_xfer(vt[i]);
            if (!vt[i].hold) idle_cycles(1);
        end
        idle_cycles(2);

        // Reset after three shifted bits must silence the line and forget the character.
        req_valid = 2'b10;
        req_char1 = 7'h33;
        #2;
        check("mid_grant", req_ready, 2'b10);
        cyc();
        req_valid = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #2;
            check("mid_bit", ser_bit, req_char1[CW-1-k]);
            cyc();
        end
        #2;
        pulse_reset("mid");
        idle_cycles(1);
        run_xfer('{2'b01, 7'h55, 7'h00, 1, 0, 0, 0, 0, 1'b0, 0});
        idle_cycles(1);

        pulse_reset("rnd");
        for (int n = 0; n < 40; n++) begin
            rt.v          = 2'($urandom_range(1, 3));
            rt.c0         = 7'($urandom);
            rt.c1         = 7'($urandom);
            rt.done_at    = int'($urandom_range(0, TO + 2));
            rt.shift_done = 1'($urandom);
            rt.hold       = 1'($urandom);
            rt.bad_echo   = ($urandom_range(0, 7) == 0);
            rt.poke       = !rt.hold && ($urandom_range(0, 3) == 0);
            rt.ew         = (rt.v == 2'b11) ? !rr_last : rt.v[1];
            rt.etimeout   = rt.done_at > int'(TO);
            run_xfer(rt);
            if (!rt.hold) idle_cycles(int'($urandom_range(0, 2)));
        end
        idle_cycles(1);
        pulse_reset("end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
